// File: rtl/serial_subtractor_dw.sv
// Multi-cycle unsigned subtractor: CW bits per clock, LSB chunk first.
// Start/busy/valid handshake; result holds until the next completion.
module serial_subtractor_dw #(
  parameter int DW = 15,
  parameter int CW = 1
) (
  input  logic          iClk,
  input  logic          iReset,
  input  logic          iStart,
  input  logic [DW-1:0] iA,
  input  logic [DW-1:0] iB,
  input  logic          iBin,
  output logic          oBusy,
  output logic          oValid,
  output logic [DW-1:0] oZ,
  output logic          oBorrow
);

  localparam int N    = DW / CW;
  localparam int CNTW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state;
  logic [DW-1:0] aReg;
  logic [DW-1:0] bReg;
  logic [DW-1:0] zPart;
  logic          borrow;
  logic [CNTW-1:0] cnt;

  logic [CW-1:0] aChunk;
  logic [CW-1:0] bChunk;
  logic [CW:0]   diff;
  logic [DW-1:0] zNext;
  logic          lastChunk;

  // Chunk subtract at CW+1 bits; the MSB is the borrow into the next chunk.
  always_comb begin
    aChunk = aReg[cnt*CW +: CW];
    bChunk = bReg[cnt*CW +: CW];
    diff   = {1'b0, aChunk} - {1'b0, bChunk} - {{CW{1'b0}}, borrow};
    zNext  = zPart;
    zNext[cnt*CW +: CW] = diff[CW-1:0];
  end

  assign lastChunk = (cnt == CNTW'(N - 1));

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      state   <= IDLE;
      aReg    <= '0;
      bReg    <= '0;
      zPart   <= '0;
      borrow  <= 1'b0;
      cnt     <= '0;
      oBusy   <= 1'b0;
      oValid  <= 1'b0;
      oZ      <= '0;
      oBorrow <= 1'b0;
    end else begin
      oValid <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (iStart) begin
            aReg   <= iA;
            bReg   <= iB;
            borrow <= iBin;
            zPart  <= '0;
            cnt    <= '0;
            oBusy  <= 1'b1;
            state  <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          zPart  <= zNext;
          borrow <= diff[CW];
          if (lastChunk) begin
            oZ      <= zNext;
            oBorrow <= diff[CW];
            oValid  <= 1'b1;
            oBusy   <= 1'b0;
            state   <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          oBusy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
